// File: rtl/branch_ctrl_pkg.sv
// Shared types and helpers for the execute-stage branch redirect controller.
// Imported by the controller top and its taken-redirect counter.
package branch_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        DRAIN    = 2'd2
    } redir_state_t;

    localparam int DRAIN_W = 3;

    // A target is usable only when word-aligned and inside the instruction memory.
    function automatic logic target_ok(input logic [31:0] target, input int pc_w);
        logic [31:0] upper;
        upper = target >> pc_w;
        return (target[1:0] == 2'b00) && (upper == 32'd0);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Registers the resolved branch target, drives the fetch redirect while fetch
// stalls, then flushes IF/ID for a fixed drain window to squash wrong-path work.
module branch_redirect_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int PC_W      = 9,
    parameter int DRAIN_CYC = 2,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ex_valid,
    input  logic             PcSel,
    input  logic [31:0]      BrPC,
    input  logic             pc_stall,
    output logic             redirect_valid,
    output logic [PC_W-1:0]  redirect_pc,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             busy,
    output logic             misalign_err,
    output logic [CNT_W-1:0] taken_count
);

    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYC);

    redir_state_t         state;
    logic [DRAIN_W-1:0]   drain_cnt;
    logic                 trigger;
    logic                 accept;

    assign trigger = ex_valid && PcSel;
    assign accept  = (state == REDIRECT) && !pc_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            drain_cnt    <= '0;
            redirect_pc  <= '0;
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= 1'b0;
            case (state)
                // Triggers are only meaningful here; in the other states they are wrong-path.
                IDLE: begin
                    if (trigger) begin
                        if (target_ok(BrPC, PC_W)) begin
                            redirect_pc <= BrPC[PC_W-1:0];
                            state       <= REDIRECT;
                        end else begin
                            misalign_err <= 1'b1;
                        end
                    end
                end
                REDIRECT: begin
                    if (!pc_stall) begin
                        drain_cnt <= DRAIN_LOAD;
                        state     <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drain_cnt <= DRAIN_W'(1)) begin
                        drain_cnt <= '0;
                        state     <= IDLE;
                    end else begin
                        drain_cnt <= drain_cnt - DRAIN_W'(1);
                    end
                end
                default: begin
                    drain_cnt <= '0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    // All outputs decode registered state, so PcSel never reaches them combinationally.
    assign redirect_valid = (state == REDIRECT);
    assign flush_idex     = (state == REDIRECT);
    assign flush_ifid     = (state == REDIRECT) || (state == DRAIN);
    assign busy           = (state != IDLE);

    sat_counter #(
        .W(CNT_W)
    ) u_taken_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (accept),
        .count(taken_count)
    );

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Self-checking bench for branch_redirect_ctrl: directed scenarios plus a
// randomized run against a cycle-level behavioural model of the redirect rules.
module tb_branch_redirect_ctrl;

    localparam int PC_W      = 9;
    localparam int DRAIN_CYC = 2;
    localparam int CNT_W     = 16;
    localparam int SAT_W     = 2;

    logic             clk;
    logic             reset;
    logic             ex_valid;
    logic             PcSel;
    logic [31:0]      BrPC;
    logic             pc_stall;

    logic             redirect_valid;
    logic [PC_W-1:0]  redirect_pc;
    logic             flush_ifid;
    logic             flush_idex;
    logic             busy;
    logic             misalign_err;
    logic [CNT_W-1:0] taken_count;

    logic             s_redirect_valid;
    logic [PC_W-1:0]  s_redirect_pc;
    logic             s_flush_ifid;
    logic             s_flush_idex;
    logic             s_busy;
    logic             s_misalign_err;
    logic [SAT_W-1:0] s_taken_count;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    bit m_redirect  = 0;
    int m_drain     = 0;
    int m_pc        = 0;
    bit m_err       = 0;
    int m_taken     = 0;
    int m_taken_sat = 0;

    branch_redirect_ctrl #(
        .PC_W(PC_W), .DRAIN_CYC(DRAIN_CYC), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .PcSel(PcSel), .BrPC(BrPC),
        .pc_stall(pc_stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .flush_ifid(flush_ifid), .flush_idex(flush_idex), .busy(busy),
        .misalign_err(misalign_err), .taken_count(taken_count)
    );

    branch_redirect_ctrl #(
        .PC_W(PC_W), .DRAIN_CYC(DRAIN_CYC), .CNT_W(SAT_W)
    ) dut_sat (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .PcSel(PcSel), .BrPC(BrPC),
        .pc_stall(pc_stall), .redirect_valid(s_redirect_valid), .redirect_pc(s_redirect_pc),
        .flush_ifid(s_flush_ifid), .flush_idex(s_flush_idex), .busy(s_busy),
        .misalign_err(s_misalign_err), .taken_count(s_taken_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock of the redirect rules, evaluated on the inputs present at the edge.
    task automatic model_step();
        bit nerr;
        longint t;
        nerr = 0;
        t = longint'(BrPC);
        if (reset) begin
            m_redirect  = 0;
            m_drain     = 0;
            m_pc        = 0;
            m_taken     = 0;
            m_taken_sat = 0;
        end else if (m_redirect) begin
            if (!pc_stall) begin
                m_redirect = 0;
                m_drain    = DRAIN_CYC;
                if (m_taken < (1 << CNT_W) - 1) m_taken++;
                if (m_taken_sat < (1 << SAT_W) - 1) m_taken_sat++;
            end
        end else if (m_drain > 0) begin
            m_drain--;
        end else if (ex_valid && PcSel) begin
            if ((t % 4 == 0) && (t < (longint'(1) << PC_W))) begin
                m_redirect = 1;
                m_pc       = int'(t);
            end else begin
                nerr = 1;
            end
        end
        m_err = reset ? 1'b0 : nerr;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input bit ev, input bit ps, input logic [31:0] pc, input bit st);
        ex_valid = ev;
        PcSel    = ps;
        BrPC     = pc;
        pc_stall = st;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(0, 0, 32'h0, 0);
        cycle();
        cycle();
        checks += 7;
        if (redirect_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_rv got=%0b exp=0", redirect_valid); end
        if (redirect_pc !== '0) begin failures++; $display("[TB] FAIL reset_pc got=%0h exp=0", redirect_pc); end
        if (flush_ifid !== 1'b0) begin failures++; $display("[TB] FAIL reset_fifid got=%0b exp=0", flush_ifid); end
        if (flush_idex !== 1'b0) begin failures++; $display("[TB] FAIL reset_fidex got=%0b exp=0", flush_idex); end
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%0b exp=0", busy); end
        if (misalign_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_err got=%0b exp=0", misalign_err); end
        if (taken_count !== '0) begin failures++; $display("[TB] FAIL reset_cnt got=%0d exp=0", taken_count); end
        reset = 1'b0;
        cycle();
    endtask

    task automatic test_taken_branch();
        drive(1, 1, 32'h0000_0040, 0);
        cycle();
        drive(0, 0, 32'h0, 0);
        checks += 4;
        if (redirect_valid !== 1'b1) begin failures++; $display("[TB] FAIL taken_rv got=%0b exp=1", redirect_valid); end
        if (redirect_pc !== 9'h040) begin failures++; $display("[TB] FAIL taken_pc got=%0h exp=40", redirect_pc); end
        if (flush_ifid !== 1'b1) begin failures++; $display("[TB] FAIL taken_fifid got=%0b exp=1", flush_ifid); end
        if (flush_idex !== 1'b1) begin failures++; $display("[TB] FAIL taken_fidex got=%0b exp=1", flush_idex); end
        for (int i = 0; i < DRAIN_CYC; i++) begin
            cycle();
            checks += 4;
            if (redirect_valid !== 1'b0) begin failures++; $display("[TB] FAIL drain%0d_rv got=%0b exp=0", i, redirect_valid); end
            if (flush_ifid !== 1'b1) begin failures++; $display("[TB] FAIL drain%0d_fifid got=%0b exp=1", i, flush_ifid); end
            if (flush_idex !== 1'b0) begin failures++; $display("[TB] FAIL drain%0d_fidex got=%0b exp=0", i, flush_idex); end
            if (busy !== 1'b1) begin failures++; $display("[TB] FAIL drain%0d_busy got=%0b exp=1", i, busy); end
        end
        cycle();
        checks += 3;
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL taken_idle_busy got=%0b exp=0", busy); end
        if (flush_ifid !== 1'b0) begin failures++; $display("[TB] FAIL taken_idle_fifid got=%0b exp=0", flush_ifid); end
        if (taken_count !== 16'd1) begin failures++; $display("[TB] FAIL taken_cnt got=%0d exp=1", taken_count); end
    endtask

    task automatic test_stall();
        int base;
        base = m_taken;
        drive(1, 1, 32'h0000_0080, 1);
        cycle();
        drive(0, 0, 32'h0, 1);
        for (int i = 0; i < 4; i++) begin
            checks += 3;
            if (redirect_valid !== 1'b1) begin failures++; $display("[TB] FAIL stall%0d_rv got=%0b exp=1", i, redirect_valid); end
            if (redirect_pc !== 9'h080) begin failures++; $display("[TB] FAIL stall%0d_pc got=%0h exp=80", i, redirect_pc); end
            if (int'(taken_count) !== base) begin failures++; $display("[TB] FAIL stall%0d_cnt got=%0d exp=%0d", i, taken_count, base); end
            pc_stall = (i < 3);
            cycle();
        end
        checks += 2;
        if (redirect_valid !== 1'b0) begin failures++; $display("[TB] FAIL stall_done_rv got=%0b exp=0", redirect_valid); end
        if (int'(taken_count) !== base + 1) begin failures++; $display("[TB] FAIL stall_done_cnt got=%0d exp=%0d", taken_count, base + 1); end
        pc_stall = 1'b0;
        cycle();
        cycle();
    endtask

    task automatic test_wrong_path();
        int base;
        base = m_taken;
        drive(1, 1, 32'h0000_0080, 1);
        cycle();
        drive(1, 1, 32'h0000_00C0, 1);
        cycle();
        checks += 2;
        if (redirect_valid !== 1'b1) begin failures++; $display("[TB] FAIL wp_redir_rv got=%0b exp=1", redirect_valid); end
        if (redirect_pc !== 9'h080) begin failures++; $display("[TB] FAIL wp_redir_pc got=%0h exp=80", redirect_pc); end
        pc_stall = 1'b0;
        cycle();
        checks += 2;
        if (redirect_valid !== 1'b0) begin failures++; $display("[TB] FAIL wp_drain_rv got=%0b exp=0", redirect_valid); end
        if (redirect_pc !== 9'h080) begin failures++; $display("[TB] FAIL wp_drain_pc got=%0h exp=80", redirect_pc); end
        cycle();
        cycle();
        drive(0, 0, 32'h0, 0);
        checks += 3;
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL wp_idle_busy got=%0b exp=0", busy); end
        if (redirect_valid !== 1'b0) begin failures++; $display("[TB] FAIL wp_idle_rv got=%0b exp=0", redirect_valid); end
        if (int'(taken_count) !== base + 1) begin failures++; $display("[TB] FAIL wp_cnt got=%0d exp=%0d", taken_count, base + 1); end
        cycle();
    endtask

    task automatic test_bad_target();
        logic [31:0] bad [2];
        int base;
        bad[0] = 32'h0000_0042;
        bad[1] = 32'h0000_0400;
        base = m_taken;
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, bad[i], 0);
            cycle();
            drive(0, 0, 32'h0, 0);
            checks += 4;
            if (misalign_err !== 1'b1) begin failures++; $display("[TB] FAIL bad%0d_err got=%0b exp=1", i, misalign_err); end
            if (busy !== 1'b0) begin failures++; $display("[TB] FAIL bad%0d_busy got=%0b exp=0", i, busy); end
            if (flush_ifid !== 1'b0) begin failures++; $display("[TB] FAIL bad%0d_fifid got=%0b exp=0", i, flush_ifid); end
            if (redirect_valid !== 1'b0) begin failures++; $display("[TB] FAIL bad%0d_rv got=%0b exp=0", i, redirect_valid); end
            cycle();
            checks += 2;
            if (misalign_err !== 1'b0) begin failures++; $display("[TB] FAIL bad%0d_pulse got=%0b exp=0", i, misalign_err); end
            if (int'(taken_count) !== base) begin failures++; $display("[TB] FAIL bad%0d_cnt got=%0d exp=%0d", i, taken_count, base); end
        end
    endtask

    task automatic test_reset_mid_drain();
        drive(1, 1, 32'h0000_0040, 0);
        cycle();
        drive(0, 0, 32'h0, 0);
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        checks += 6;
        if (redirect_valid !== 1'b0) begin failures++; $display("[TB] FAIL rmd_rv got=%0b exp=0", redirect_valid); end
        if (flush_ifid !== 1'b0) begin failures++; $display("[TB] FAIL rmd_fifid got=%0b exp=0", flush_ifid); end
        if (flush_idex !== 1'b0) begin failures++; $display("[TB] FAIL rmd_fidex got=%0b exp=0", flush_idex); end
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL rmd_busy got=%0b exp=0", busy); end
        if (taken_count !== '0) begin failures++; $display("[TB] FAIL rmd_cnt got=%0d exp=0", taken_count); end
        if (redirect_pc !== '0) begin failures++; $display("[TB] FAIL rmd_pc got=%0h exp=0", redirect_pc); end
        drive(1, 1, 32'h0000_0100, 0);
        cycle();
        drive(0, 0, 32'h0, 0);
        checks += 2;
        if (redirect_valid !== 1'b1) begin failures++; $display("[TB] FAIL rmd_fresh_rv got=%0b exp=1", redirect_valid); end
        if (redirect_pc !== 9'h100) begin failures++; $display("[TB] FAIL rmd_fresh_pc got=%0h exp=100", redirect_pc); end
        cycle();
        cycle();
        cycle();
    endtask

    task automatic test_back_to_back();
        drive(1, 1, 32'h0000_0020, 0);
        cycle();
        drive(0, 0, 32'h0, 0);
        cycle();
        cycle();
        cycle();
        checks += 1;
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL b2b_idle_busy got=%0b exp=0", busy); end
        drive(1, 1, 32'h0000_0060, 0);
        cycle();
        drive(0, 0, 32'h0, 0);
        checks += 2;
        if (redirect_valid !== 1'b1) begin failures++; $display("[TB] FAIL b2b_rv got=%0b exp=1", redirect_valid); end
        if (redirect_pc !== 9'h060) begin failures++; $display("[TB] FAIL b2b_pc got=%0h exp=60", redirect_pc); end
        cycle();
        cycle();
        cycle();
    endtask

    task automatic test_saturation();
        int exp_sat;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            drive(1, 1, 32'h0000_0010 * k, 0);
            cycle();
            drive(0, 0, 32'h0, 0);
            cycle();
            cycle();
            cycle();
            exp_sat = (k > 3) ? 3 : k;
            checks += 2;
            if (int'(s_taken_count) !== exp_sat) begin failures++; $display("[TB] FAIL sat%0d_cnt got=%0d exp=%0d", k, s_taken_count, exp_sat); end
            if (int'(taken_count) !== k) begin failures++; $display("[TB] FAIL wide%0d_cnt got=%0d exp=%0d", k, taken_count, k); end
        end
    endtask

    task automatic test_random();
        bit exp_flush;
        for (int n = 0; n < 400; n++) begin
            reset    = ($urandom_range(0, 99) < 2);
            ex_valid = $urandom_range(0, 1);
            PcSel    = $urandom_range(0, 1);
            pc_stall = ($urandom_range(0, 9) < 4);
            case ($urandom_range(0, 3))
                0, 1:    BrPC = {23'd0, 7'($urandom_range(0, 127)), 2'b00};
                2:       BrPC = {23'd0, 7'($urandom_range(0, 127)), 2'($urandom_range(1, 3))};
                default: BrPC = $urandom | 32'h0000_0200;
            endcase
            cycle();
            exp_flush = m_redirect || (m_drain > 0);
            checks += 7;
            if (redirect_valid !== m_redirect) begin failures++; $display("[TB] FAIL rnd%0d_rv got=%0b exp=%0b", n, redirect_valid, m_redirect); end
            if (flush_ifid !== exp_flush) begin failures++; $display("[TB] FAIL rnd%0d_fifid got=%0b exp=%0b", n, flush_ifid, exp_flush); end
            if (flush_idex !== m_redirect) begin failures++; $display("[TB] FAIL rnd%0d_fidex got=%0b exp=%0b", n, flush_idex, m_redirect); end
            if (busy !== exp_flush) begin failures++; $display("[TB] FAIL rnd%0d_busy got=%0b exp=%0b", n, busy, exp_flush); end
            if (misalign_err !== m_err) begin failures++; $display("[TB] FAIL rnd%0d_err got=%0b exp=%0b", n, misalign_err, m_err); end
            if (int'(taken_count) !== m_taken) begin failures++; $display("[TB] FAIL rnd%0d_cnt got=%0d exp=%0d", n, taken_count, m_taken); end
            if (int'(s_taken_count) !== m_taken_sat) begin failures++; $display("[TB] FAIL rnd%0d_satcnt got=%0d exp=%0d", n, s_taken_count, m_taken_sat); end
            if (m_redirect) begin
                checks++;
                if (int'(redirect_pc) !== m_pc) begin failures++; $display("[TB] FAIL rnd%0d_pc got=%0h exp=%0h", n, redirect_pc, m_pc); end
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 32'h0, 0);
        test_reset();
        test_taken_branch();
        test_stall();
        test_wrong_path();
        test_bad_target();
        test_reset_mid_drain();
        test_back_to_back();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
- Sequences the PC redirect produced by the execute-stage branch resolution logic.
- Each cycle it samples the resolved branch decision (PcSel) and target (BrPC), registers the target and drives the fetch-stage redirect.
- Holds the redirect while fetch is stalled, then asserts pipeline flushes for a fixed drain window so that wrong-path instructions are squashed.
- Also flags misaligned or out-of-range targets and keeps a saturating count of taken redirects for debug.

Parameters:
- PC_W, 9, width of the instruction-memory PC.
- DRAIN_CYC, 2, cycles of post-redirect IF/ID flush; legal range 1..7.
- CNT_W, 16, width of the taken-redirect counter.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high; one clock, one synchronous active-high reset.
- ex_valid  input  1  execute stage holds a valid instruction this cycle.
- PcSel  input  1  branch/jump resolved taken.
- BrPC  input  32  resolved target address.
- pc_stall  input  1  fetch cannot accept a redirect this cycle.
- redirect_valid  output  1  redirect request to fetch.
- redirect_pc  output  PC_W  target PC, valid while redirect_valid.
- flush_ifid  output  1  clear the IF/ID pipeline register.
- flush_idex  output  1  clear the ID/EX pipeline register.
- busy  output  1  state is not IDLE.
- misalign_err  output  1  one-cycle pulse: a taken target was rejected.
- taken_count  output  CNT_W  saturating count of accepted redirects.

Behaviour:
- Reset: state=IDLE; all outputs 0, including redirect_pc, taken_count and the drain counter. Reset mid-REDIRECT or mid-DRAIN aborts with no further flush, and the pending target is discarded.
- Trigger: ex_valid && PcSel, sampled in IDLE only. In REDIRECT or DRAIN the triggering instruction is wrong-path and is ignored. No queueing.
- Target check at the trigger:
  - BrPC[1:0]!=0, or BrPC[31:PC_W]!=0, means reject.
  - On reject: misalign_err=1 in cycle N+1, state stays IDLE, no redirect, taken_count unchanged.
  - Otherwise: capture BrPC[PC_W-1:0] into redirect_pc and go to REDIRECT.
- Latency: trigger at edge N gives redirect_valid=1 in cycle N+1. Registered output; no combinational path from PcSel to any output.
- REDIRECT state:
  - Outputs: redirect_valid=1, flush_ifid=1, flush_idex=1, busy=1.
  - pc_stall=1: remain in REDIRECT; outputs and redirect_pc held stable.
  - pc_stall=0: the redirect is accepted at that edge. taken_count increments (saturates at all-ones, no wrap), drain counter loads DRAIN_CYC, and the next state is DRAIN.
- DRAIN state:
  - Outputs: flush_ifid=1, flush_idex=0, redirect_valid=0, busy=1.
  - Counter decrements each cycle regardless of pc_stall.
  - Next state is IDLE at the edge where the counter reaches 1, giving exactly DRAIN_CYC DRAIN cycles.
- IDLE: all flush and redirect outputs 0. redirect_pc retains its last value (don't-care).
- A trigger on the first IDLE cycle after DRAIN is honoured; back-to-back redirects are legal.
- The state encoding is an enum of IDLE, REDIRECT, DRAIN; an unreachable encoding returns to IDLE.

Decomposition:
- Shared package branch_ctrl_pkg holds:
  - enum redir_state_t {IDLE, REDIRECT, DRAIN};
  - localparam DRAIN_W = 3;
  - a function checking target alignment and range, parameterised on PC_W.
- One natural sub-module, sat_counter (parameter W; ports clk, reset, inc, count), which implements taken_count.

Test Plan:
- Reset then taken branch: ex_valid=1, PcSel=1, BrPC=0x0000_0040, pc_stall=0 at edge 5 -> redirect_valid=1, redirect_pc=0x040, flush_ifid=flush_idex=1 in cycle 6 only. flush_ifid stays 1 in cycles 7–8 (DRAIN_CYC=2). busy=0 and taken_count=1 in cycle 9.
- Stalled redirect: BrPC=0x080, pc_stall=1 for 3 cycles after the trigger -> redirect_valid and redirect_pc=0x080 held for 4 cycles. taken_count increments once, at the accepting edge.
- Wrong-path suppression: a second PcSel=1 with BrPC=0x0C0 during REDIRECT and during DRAIN -> ignored, redirect_pc stays 0x080, taken_count unchanged.
- Bad target: BrPC=0x0000_0042, then BrPC=0x0000_0400 (PC_W=9) -> misalign_err pulses one cycle each, busy stays 0, no flush.
- Reset mid-DRAIN: assert reset in DRAIN cycle 1 -> next cycle all outputs 0 and taken_count=0. A fresh trigger redirects normally.
- Saturation: CNT_W=2, 5 accepted redirects -> taken_count reads 3 after the third redirect and stays 3.
